// File: rtl/ntm_write_weighting.sv
// ntm_write_weighting: streams the DNC write weighting
//   w[i] = gw * (ga*a[i] + (ONE-ga)*c[i])
// in unsigned fixed point with FRACTION_SIZE fractional bits.
module ntm_write_weighting #(
   parameter int DATA_SIZE     = 64,
   parameter int FRACTION_SIZE = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic [DATA_SIZE-1:0] SIZE_N_IN,
   input  logic [DATA_SIZE-1:0] GA_IN,
   input  logic [DATA_SIZE-1:0] GW_IN,
   input  logic                 A_IN_ENABLE,
   input  logic [DATA_SIZE-1:0] A_IN,
   input  logic                 C_IN_ENABLE,
   input  logic [DATA_SIZE-1:0] C_IN,
   output logic                 W_OUT_ENABLE,
   output logic [DATA_SIZE-1:0] W_OUT
);

   localparam int unsigned DW = DATA_SIZE;
   localparam int unsigned PW = 2 * DATA_SIZE;
   localparam logic [DW-1:0] ONE = DW'(1) << FRACTION_SIZE;

   typedef enum logic [2:0] {
      IDLE,
      INPUT,
      STAGE1,
      STAGE2,
      ENDER
   } state_t;

   state_t        state;
   logic [DW-1:0] n_r;
   logic [DW-1:0] index_r;
   logic [DW-1:0] ga_r;
   logic [DW-1:0] gw_r;
   logic [DW-1:0] a_hold;
   logic [DW-1:0] c_hold;
   logic          a_valid;
   logic          c_valid;
   logic [DW-1:0] s_r;

   logic [DW-1:0] ga_sat_c;
   logic [DW-1:0] gw_sat_c;
   logic [DW-1:0] a_sel_c;
   logic [DW-1:0] c_sel_c;
   logic [DW-1:0] term_a_c;
   logic [DW-1:0] term_c_c;
   logic [DW:0]   sum_c;
   logic [DW-1:0] s_sat_c;
   logic [DW-1:0] w_c;
   logic          pair_done_c;

   // Gate saturation, operand forwarding for same-cycle capture, and the datapath math
   always_comb begin
      ga_sat_c    = (GA_IN > ONE) ? ONE : GA_IN;
      gw_sat_c    = (GW_IN > ONE) ? ONE : GW_IN;
      a_sel_c     = A_IN_ENABLE ? A_IN : a_hold;
      c_sel_c     = C_IN_ENABLE ? C_IN : c_hold;
      term_a_c    = DW'((PW'(ga_r) * PW'(a_sel_c)) >> FRACTION_SIZE);
      term_c_c    = DW'((PW'(ONE - ga_r) * PW'(c_sel_c)) >> FRACTION_SIZE);
      sum_c       = {1'b0, term_a_c} + {1'b0, term_c_c};
      s_sat_c     = sum_c[DW] ? '1 : sum_c[DW-1:0];
      w_c         = DW'((PW'(gw_r) * PW'(s_r)) >> FRACTION_SIZE);
      pair_done_c = (a_valid | A_IN_ENABLE) & (c_valid | C_IN_ENABLE);
   end

   // Pass sequencing, operand capture and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         n_r          <= '0;
         index_r      <= '0;
         ga_r         <= '0;
         gw_r         <= '0;
         a_hold       <= '0;
         c_hold       <= '0;
         a_valid      <= 1'b0;
         c_valid      <= 1'b0;
         s_r          <= '0;
         READY        <= 1'b0;
         W_OUT_ENABLE <= 1'b0;
         W_OUT        <= '0;
      end else begin
         READY        <= 1'b0;
         W_OUT_ENABLE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  n_r     <= SIZE_N_IN;
                  ga_r    <= ga_sat_c;
                  gw_r    <= gw_sat_c;
                  index_r <= '0;
                  a_valid <= 1'b0;
                  c_valid <= 1'b0;
                  if (SIZE_N_IN == '0) begin
                     READY <= 1'b1;
                     state <= ENDER;
                  end else begin
                     state <= INPUT;
                  end
               end
            end
            INPUT: begin
               if (A_IN_ENABLE) begin
                  a_hold  <= A_IN;
                  a_valid <= 1'b1;
               end
               if (C_IN_ENABLE) begin
                  c_hold  <= C_IN;
                  c_valid <= 1'b1;
               end
               // The blended sum is registered as the pair completes, so it is ready in STAGE1
               if (pair_done_c) begin
                  s_r     <= s_sat_c;
                  a_valid <= 1'b0;
                  c_valid <= 1'b0;
                  state   <= STAGE1;
               end
            end
            STAGE1: begin
               W_OUT        <= w_c;
               W_OUT_ENABLE <= 1'b1;
               state        <= STAGE2;
            end
            STAGE2: begin
               if (index_r == n_r - DW'(1)) begin
                  READY <= 1'b1;
                  state <= ENDER;
               end else begin
                  index_r <= index_r + DW'(1);
                  state   <= INPUT;
               end
            end
            ENDER: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntm_write_weighting.sv
// Scoreboard bench for ntm_write_weighting: stimulus pushes expected outputs
// tagged with the cycle they must appear in; a monitor pops and compares.
module tb_ntm_write_weighting;

   localparam logic [63:0] ONE = 64'h1_0000_0000;

   typedef struct {
      bit          rdy;
      logic [63:0] w;
      int          cyc;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic        START;
   logic        READY;
   logic [63:0] SIZE_N_IN;
   logic [63:0] GA_IN;
   logic [63:0] GW_IN;
   logic        A_IN_ENABLE;
   logic [63:0] A_IN;
   logic        C_IN_ENABLE;
   logic [63:0] C_IN;
   logic        W_OUT_ENABLE;
   logic [63:0] W_OUT;

   exp_t sb[$];
   int   cyc         = 0;
   int   vectors     = 0;
   int   miscompares = 0;

   ntm_write_weighting #(.DATA_SIZE(64), .FRACTION_SIZE(32)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .START        (START),
      .READY        (READY),
      .SIZE_N_IN    (SIZE_N_IN),
      .GA_IN        (GA_IN),
      .GW_IN        (GW_IN),
      .A_IN_ENABLE  (A_IN_ENABLE),
      .A_IN         (A_IN),
      .C_IN_ENABLE  (C_IN_ENABLE),
      .C_IN         (C_IN),
      .W_OUT_ENABLE (W_OUT_ENABLE),
      .W_OUT        (W_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   // Monitor: every output event must match the head of the scoreboard, value and cycle
   always @(negedge CLK) begin
      if (W_OUT_ENABLE || READY) begin
         vectors++;
         if (W_OUT_ENABLE && READY) begin
            miscompares++;
            $display("FAIL overlap: W_OUT_ENABLE and READY both high at cyc %0d", cyc);
         end else if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: en=%0b rdy=%0b w=%h at cyc %0d, nothing expected",
                     W_OUT_ENABLE, READY, W_OUT, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.rdy != READY || (!e.rdy && W_OUT !== e.w) || e.cyc != cyc)
            begin
               miscompares++;
               $display("FAIL scoreboard: got rdy=%0b w=%h cyc=%0d, expected rdy=%0b w=%h cyc=%0d",
                        READY, W_OUT, cyc, e.rdy, e.w, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input bit rdy, input logic [63:0] w, input int at);
      exp_t e;
      e.rdy = rdy;
      e.w   = w;
      e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // START for one cycle; gate/size inputs are then scrambled to prove they were latched
   task automatic start_pass(input logic [63:0] n, input logic [63:0] ga, input logic [63:0] gw);
      START     = 1'b1;
      SIZE_N_IN = n;
      GA_IN     = ga;
      GW_IN     = gw;
      if (n == 64'd0) push(1'b1, 64'd0, cyc + 1);
      tick();
      START     = 1'b0;
      SIZE_N_IN = 64'd7;
      GA_IN     = 64'hFFFF_FFFF_FFFF_FFFF;
      GW_IN     = 64'd0;
   endtask

   task automatic strobe(input bit ea, input bit ec, input logic [63:0] a, input logic [63:0] c,
                         input bit chk, input logic [63:0] w, input bit last);
      A_IN_ENABLE = ea;
      C_IN_ENABLE = ec;
      A_IN        = a;
      C_IN        = c;
      if (chk) begin
         push(1'b0, w, cyc + 2);
         if (last) push(1'b1, 64'd0, cyc + 3);
      end
      tick();
      A_IN_ENABLE = 1'b0;
      C_IN_ENABLE = 1'b0;
   endtask

   task automatic pair(input logic [63:0] a, input logic [63:0] c, input logic [63:0] w,
                       input bit last);
      strobe(1'b1, 1'b1, a, c, 1'b1, w, last);
      idle(2);
   endtask

   initial begin
      RST = 1'b0; START = 1'b0;
      SIZE_N_IN = '0; GA_IN = '0; GW_IN = '0;
      A_IN_ENABLE = 1'b0; A_IN = '0; C_IN_ENABLE = 1'b0; C_IN = '0;
      idle(2);
      check("reset_w_out", W_OUT, 64'd0);
      check("reset_w_en", {63'd0, W_OUT_ENABLE}, 64'd0);
      check("reset_ready", {63'd0, READY}, 64'd0);
      RST = 1'b1;
      idle(2);

      // Basic element: 0.5*0.25 + 0.5*0.75 = 0.5
      start_pass(64'd1, 64'h8000_0000, ONE);
      pair(64'h4000_0000, 64'hC000_0000, 64'h8000_0000, 1'b1);
      idle(1);

      // ga = ONE, gw = 0.5: w = a/2, c irrelevant
      start_pass(64'd3, ONE, 64'h8000_0000);
      pair(ONE,          64'h1234_5678_9ABC, 64'h8000_0000, 1'b0);
      pair(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000, 1'b0);
      pair(64'd0,        64'h7777, 64'd0, 1'b1);
      idle(1);

      // gw = 0: everything zero
      start_pass(64'd3, ONE, 64'd0);
      pair(ONE,          64'h1234_5678_9ABC, 64'd0, 1'b0);
      pair(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
      pair(64'd0,        64'h7777, 64'd0, 1'b1);
      idle(1);

      // Split strobes, then overwrite of A: ga=0.25
      start_pass(64'd2, 64'h4000_0000, ONE);
      strobe(1'b1, 1'b0, ONE, 64'd0, 1'b0, 64'd0, 1'b0);
      idle(2);
      strobe(1'b0, 1'b1, 64'd0, 64'd0, 1'b1, 64'h4000_0000, 1'b0);
      idle(2);
      strobe(1'b1, 1'b0, 64'hFFFF_FFFF, 64'd0, 1'b0, 64'd0, 1'b0);
      strobe(1'b1, 1'b0, 64'h8000_0000, 64'd0, 1'b0, 64'd0, 1'b0);
      strobe(1'b0, 1'b1, 64'd0, 64'h8000_0000, 1'b1, 64'h8000_0000, 1'b1);
      idle(3);

      // Oversized gates saturate to ONE: w = a
      start_pass(64'd1, 64'hFFFF_FFFF_FFFF, 64'h2_0000_0000);
      pair(64'h3000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3000_0000, 1'b1);
      idle(1);

      // N = 0: READY one cycle after START, no data
      start_pass(64'd0, ONE, ONE);
      idle(2);

      // Reset mid-pass after 2 of 4 elements
      start_pass(64'd4, ONE, ONE);
      pair(64'h1111_0000, 64'd5, 64'h1111_0000, 1'b0);
      pair(64'h2222_0000, 64'd6, 64'h2222_0000, 1'b0);
      RST = 1'b0;
      #1;
      check("midreset_w_out", W_OUT, 64'd0);
      check("midreset_w_en", {63'd0, W_OUT_ENABLE}, 64'd0);
      check("midreset_ready", {63'd0, READY}, 64'd0);
      tick();
      RST = 1'b1;
      idle(1);

      // Strobes in IDLE are discarded
      strobe(1'b1, 1'b1, 64'h9999, 64'h9999, 1'b0, 64'd0, 1'b0);
      idle(2);

      // Fresh pass, ga = 0 so w = c; a START with new settings during INPUT is ignored
      start_pass(64'd4, 64'd0, ONE);
      START = 1'b1; SIZE_N_IN = 64'd1; GA_IN = ONE; GW_IN = 64'd0;
      strobe(1'b1, 1'b0, 64'h5555, 64'd0, 1'b0, 64'd0, 1'b0);
      START = 1'b0;
      strobe(1'b0, 1'b1, 64'd0, 64'h100, 1'b1, 64'h100, 1'b0);
      idle(2);
      pair(64'h5555, 64'h200, 64'h200, 1'b0);
      pair(64'h5555, 64'h300, 64'h300, 1'b0);
      pair(64'h5555, 64'h400, 64'h400, 1'b1);
      idle(4);

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ntm_write_weighting.md
# ntm_write_weighting

Computes the DNC write weighting w[i] = gw·(ga·a[i] + (1−ga)·c[i]) over N memory locations. It sits directly downstream of the write heads: it consumes the allocation gate ga and write gate gw, plus the streamed allocation weighting a and content weighting c. It streams w to the memory-update stage. All data is unsigned fixed point with FRACTION_SIZE fractional bits, so ONE = 2^FRACTION_SIZE.

## Interface
- DATA_SIZE, 64, width of every data word.
- FRACTION_SIZE, 32, fractional bits of the fixed-point format; must be < DATA_SIZE.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  begins a pass; sampled only in IDLE.
- READY  out  1  one-cycle pulse when a pass completes.
- SIZE_N_IN  in  DATA_SIZE  number of locations N; latched at START.
- GA_IN  in  DATA_SIZE  allocation gate; latched at START.
- GW_IN  in  DATA_SIZE  write gate; latched at START.
- A_IN_ENABLE  in  1  strobe for A_IN.
- A_IN  in  DATA_SIZE  allocation weighting element a[i].
- C_IN_ENABLE  in  1  strobe for C_IN.
- C_IN  in  DATA_SIZE  content weighting element c[i].
- W_OUT_ENABLE  out  1  one-cycle strobe qualifying W_OUT.
- W_OUT  out  DATA_SIZE  write weighting element w[i].

## Operation
- States: IDLE, INPUT, STAGE1, STAGE2, ENDER.
- IDLE
  - On START=1, latch N, ga and gw, and set index=0.
  - ga and gw saturate to ONE if they exceed ONE.
  - If N=0, go to ENDER; otherwise go to INPUT.
- INPUT
  - A_IN_ENABLE captures A_IN into a holding register and sets a_valid.
  - C_IN_ENABLE captures C_IN into a holding register and sets c_valid.
  - Both may arrive in the same cycle or in any order.
  - A repeated strobe on a side that is already valid overwrites that held value (last wins).
  - When both sides are valid at the end of a cycle (including same-cycle capture), go to STAGE1 and clear both valid flags.
- STAGE1: register s = sat(((ga·a)>>F) + (((ONE−ga)·c)>>F)).
  - Each product is 2·DATA_SIZE bits wide and is truncated after the shift.
  - The sum saturates at 2^DATA_SIZE−1.
- STAGE2
  - Drive W_OUT = (gw·s)>>F, truncated to DATA_SIZE bits, and assert W_OUT_ENABLE.
  - If index = N−1, go to ENDER; otherwise increment index and return to INPUT.
- ENDER: assert READY for one cycle, then go to IDLE.
- START outside IDLE is ignored. Strobes outside INPUT are ignored and discarded.
- GA_IN, GW_IN and SIZE_N_IN changing mid-pass have no effect.

## Timing
- Reset (RST=0, asynchronous) forces IDLE immediately, clears index and both valid flags, and sets READY=0, W_OUT_ENABLE=0, W_OUT=0.
  - Takes effect even mid-pass; any partial output stream is abandoned.
- START accepted in cycle t: INPUT is entered at t+1, so the earliest strobe is accepted in cycle t+1.
- Pair completed in cycle t: STAGE1 at t+1; W_OUT_ENABLE=1 with valid W_OUT at t+2.
- After W_OUT_ENABLE, the block is back in INPUT on the next cycle. Peak throughput is one element per 3 cycles.
- READY pulses in the cycle after the final W_OUT_ENABLE.
- For N=0, READY pulses at t+1 after START.
- W_OUT holds its last value between strobes. W_OUT_ENABLE and READY are never high in the same cycle.
- Minimum restart: START may be asserted in the cycle after READY.

## Test plan
- Basic element: N=1, ga=0x8000_0000 (0.5), gw=0x1_0000_0000 (1.0), a=0x4000_0000, c=0xC000_0000 sent together.
  - Required: W_OUT=0x8000_0000 exactly 2 cycles after the strobe, then READY pulses one cycle later.
- Gate extremes: N=3, ga=ONE, gw=0x8000_0000, a={ONE, 0x8000_0000, 0}, c=arbitrary.
  - Required: w={0x8000_0000, 0x4000_0000, 0}.
- Gate extremes: repeat with gw=0.
  - Required: all three w=0, then READY.
- Split and overwrite strobes: A then C 3 cycles apart, and A sent twice before C.
  - Required: output appears 2 cycles after the C strobe and uses the second A value.
- Saturation/size edges: ga_in=0xFFFF_FFFF_FFFF (treated as ONE), and N=0.
  - Required: w=gw·a (ga saturated to ONE).
  - Required (N=0): READY at t+1 after START, with no W_OUT_ENABLE.
- Reset and ignored inputs: RST low after 2 of 4 elements.
  - Required: outputs are 0 at once.
  - Required: a new START then completes 4 fresh elements.
  - Required: START during INPUT and strobes in IDLE cause no change.
